// File: rtl/sum_uart_rx.sv
// 8N1 UART receiver for the sum/latch transmitter: recovers each byte, exposes the 5-bit sum,
// and hands it off on a valid/ack handshake with overrun and framing-error reporting.
module sum_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       uart_rxd_i,
    input  logic       rx_ack_i,
    output logic [7:0] rx_data_o,
    output logic [4:0] rx_sum_o,
    output logic       rx_sum_ok_o,
    output logic       rx_valid_o,
    output logic       rx_overrun_o,
    output logic       rx_frame_err_o,
    output logic       rx_busy_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned Half = CLKS_PER_BIT / 2;
    localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitHigh = 3'd4;

    logic            sync1_q, sync2_q;
    logic            rxd_s;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic            ferr_q, ferr_d;
    logic            byte_done;
    logic            ack_eff;

    assign rxd_s = sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        ferr_d    = 1'b0;
        byte_done = 1'b0;

        case (state_q)
            StIdle: begin
                if (!rxd_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                // A high line at mid-start is a glitch, not a frame.
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxd_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxd_s;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        byte_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitHigh: begin
                if (rxd_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A completing byte always wins over an ack in the same cycle.
    always_comb begin
        ack_eff = rx_ack_i && valid_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (byte_done) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            if (ack_eff) begin
                ovr_d = 1'b0;
            end else if (valid_q) begin
                ovr_d = 1'b1;
            end
        end else if (ack_eff) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rxd_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data_o      = data_q;
    assign rx_sum_o       = data_q[4:0];
    assign rx_sum_ok_o    = (data_q[7:5] == 3'b000);
    assign rx_valid_o     = valid_q;
    assign rx_overrun_o   = ovr_q;
    assign rx_frame_err_o = ferr_q;
    assign rx_busy_o      = (state_q != StIdle);

endmodule
